// File: rtl/demux1to8x2_reg_pkg.sv
// Shared constants and helpers for the dual 1-to-8 registered demultiplexer.
// NL must equal 2**SW; both are fixed here so every channel agrees on lane indexing.
package demux1to8x2_reg_pkg;

   localparam int NL = 8;
   localparam int SW = 3;
   localparam int OW = 4;

   function automatic int lane_lsb(input int lane, input int dw);
      return lane * dw;
   endfunction

   // NOTE: blocking '=' is correct inside functions and always_comb; only
   // clocked state uses '<='.
   function automatic logic [OW-1:0] popcount(input logic [NL-1:0] v);
      logic [OW-1:0] n;
      n = '0;
      for (int i = 0; i < NL; i++) n = n + OW'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/demux1to8x2_reg_chan.sv
// One demux channel: steers an input word into one of eight holding registers,
// each drained by its own valid/ready handshake, plus a registered occupancy count.
(* keep_hierarchy = "yes" *)
module demux1to8_reg
   import demux1to8x2_reg_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_in_vld,
   input  logic [SW-1:0]    i_in_sel,
   input  logic [DW-1:0]    i_in_data,
   output logic             o_in_rdy,
   output logic [NL-1:0]    o_out_vld,
   output logic [NL*DW-1:0] o_out_data,
   input  logic [NL-1:0]    i_out_rdy,
   output logic [OW-1:0]    o_occ
);

   logic [NL-1:0] r_vld;
   logic [DW-1:0] r_data [NL];
   logic [OW-1:0] r_occ;
   logic [NL-1:0] w_load;
   logic [NL-1:0] w_vld_nxt;
   logic          w_acc;

   // A lane may take a word if it is empty or is draining this same edge.
   assign o_in_rdy = i_rst_n & (~r_vld[i_in_sel] | i_out_rdy[i_in_sel]);
   assign w_acc    = i_in_vld & o_in_rdy;

   // NOTE: default every always_comb output first so no latch is inferred.
   always_comb begin
      w_load = '0;
      if (w_acc) w_load[i_in_sel] = 1'b1;
   end

   assign w_vld_nxt = w_load | (r_vld & ~i_out_rdy);

   // NOTE: lane data is reset because a zero out_data after reset is visible
   // to consumers; otherwise only the valid bits would need a reset.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
         r_occ <= '0;
         for (int k = 0; k < NL; k++) r_data[k] <= '0;
      end else begin
         r_vld <= w_vld_nxt;
         r_occ <= popcount(w_vld_nxt);
         for (int k = 0; k < NL; k++) begin
            if (w_load[k]) r_data[k] <= i_in_data;
         end
      end
   end

   for (genvar k = 0; k < NL; k++) begin : g_lane
      assign o_out_data[lane_lsb(k, DW) +: DW] = r_data[k];
   end

   assign o_out_vld = r_vld;
   assign o_occ     = r_occ;

endmodule

// File: rtl/demux1to8x2_reg.sv
// Dual, fully independent 1-to-8 registered demultiplexer; two channels share
// one placement region but no state.
module demux1to8x2_reg
   import demux1to8x2_reg_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_vld0,
   input  logic [SW-1:0]    in_sel0,
   input  logic [DW-1:0]    in_data0,
   output logic             in_rdy0,
   input  logic             in_vld1,
   input  logic [SW-1:0]    in_sel1,
   input  logic [DW-1:0]    in_data1,
   output logic             in_rdy1,
   output logic [NL-1:0]    out_vld0,
   output logic [NL*DW-1:0] out_data0,
   input  logic [NL-1:0]    out_rdy0,
   output logic [NL-1:0]    out_vld1,
   output logic [NL*DW-1:0] out_data1,
   input  logic [NL-1:0]    out_rdy1,
   output logic [OW-1:0]    occ0,
   output logic [OW-1:0]    occ1
);

   demux1to8_reg #(.DW(DW)) u_ch0 (
      .clk        (clk),
      .i_rst_n    (reset_n),
      .i_in_vld   (in_vld0),
      .i_in_sel   (in_sel0),
      .i_in_data  (in_data0),
      .o_in_rdy   (in_rdy0),
      .o_out_vld  (out_vld0),
      .o_out_data (out_data0),
      .i_out_rdy  (out_rdy0),
      .o_occ      (occ0)
   );

   demux1to8_reg #(.DW(DW)) u_ch1 (
      .clk        (clk),
      .i_rst_n    (reset_n),
      .i_in_vld   (in_vld1),
      .i_in_sel   (in_sel1),
      .i_in_data  (in_data1),
      .o_in_rdy   (in_rdy1),
      .o_out_vld  (out_vld1),
      .o_out_data (out_data1),
      .i_out_rdy  (out_rdy1),
      .o_occ      (occ1)
   );

endmodule

// File: tb/tb_demux1to8x2_reg.sv
// Directed bench for demux1to8x2_reg: reset, single transfer, back-pressure,
// pass-through, fill-to-full, asynchronous reset with held lanes, channel independence.
module tb_demux1to8x2_reg;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_vld0, in_vld1;
   logic [2:0]    in_sel0, in_sel1;
   logic [DW-1:0] in_data0, in_data1;
   logic          in_rdy0, in_rdy1;
   logic [7:0]    out_vld0, out_vld1;
   logic [8*DW-1:0] out_data0, out_data1;
   logic [7:0]    out_rdy0, out_rdy1;
   logic [3:0]    occ0, occ1;

   int n_vec = 0;
   int n_err = 0;

   demux1to8x2_reg #(.DW(DW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_vld0   (in_vld0),
      .in_sel0   (in_sel0),
      .in_data0  (in_data0),
      .in_rdy0   (in_rdy0),
      .in_vld1   (in_vld1),
      .in_sel1   (in_sel1),
      .in_data1  (in_data1),
      .in_rdy1   (in_rdy1),
      .out_vld0  (out_vld0),
      .out_data0 (out_data0),
      .out_rdy0  (out_rdy0),
      .out_vld1  (out_vld1),
      .out_data1 (out_data1),
      .out_rdy1  (out_rdy1),
      .occ0      (occ0),
      .occ1      (occ1)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1ns after a rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] lane0(input int k);
      return out_data0[k*DW +: DW];
   endfunction

   function automatic logic [63:0] lane1(input int k);
      return out_data1[k*DW +: DW];
   endfunction

   initial begin
      reset_n  = 1'b0;
      in_vld0  = 1'b0; in_sel0 = '0; in_data0 = '0; out_rdy0 = '0;
      in_vld1  = 1'b0; in_sel1 = '0; in_data1 = '0; out_rdy1 = '0;

      // Reset state and empty-channel readiness
      step(); step();
      check("rst_in_rdy0", 64'(in_rdy0), 64'd0);
      check("rst_in_rdy1", 64'(in_rdy1), 64'd0);
      check("rst_vld0", 64'(out_vld0), 64'h00);
      check("rst_occ0", 64'(occ0), 64'd0);
      #2 reset_n = 1'b1;
      step();
      for (int s = 0; s < 8; s++) begin
         in_sel0 = 3'(s);
         #1 check($sformatf("empty_rdy0_sel%0d", s), 64'(in_rdy0), 64'd1);
      end

      // Single transfer into lane 3
      in_vld0 = 1'b1; in_sel0 = 3'd3; in_data0 = 64'hA5A5_0000_0000_0003; out_rdy0 = '0;
      step();
      in_vld0 = 1'b0;
      check("single_vld0", 64'(out_vld0), 64'h08);
      check("single_data3", lane0(3), 64'hA5A5_0000_0000_0003);
      check("single_occ0", 64'(occ0), 64'd1);

      // Back-pressure on lane 3, other lanes still accepted
      in_vld0 = 1'b1; in_sel0 = 3'd3; in_data0 = 64'hDEAD_BEEF_0000_0033;
      #1 check("bp_rdy0_sel3", 64'(in_rdy0), 64'd0);
      step();
      check("bp_data3_held", lane0(3), 64'hA5A5_0000_0000_0003);
      check("bp_vld0", 64'(out_vld0), 64'h08);
      in_sel0 = 3'd4; in_data0 = 64'h0000_0000_0000_0044;
      #1 check("bp_rdy0_sel4", 64'(in_rdy0), 64'd1);
      step();
      in_vld0 = 1'b0;
      check("bp_vld0_34", 64'(out_vld0), 64'h18);
      check("bp_data4", lane0(4), 64'h44);
      check("bp_occ0", 64'(occ0), 64'd2);

      // Drain everything; data registers keep their value
      out_rdy0 = 8'hFF;
      step();
      out_rdy0 = '0;
      check("drain_vld0", 64'(out_vld0), 64'h00);
      check("drain_occ0", 64'(occ0), 64'd0);
      check("drain_data3_kept", lane0(3), 64'hA5A5_0000_0000_0003);

      // Pass-through on lane 6 with simultaneous drain and reload
      out_rdy0 = 8'h40; in_sel0 = 3'd6; in_vld0 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_data0 = 64'(i);
         #1 check($sformatf("pt_rdy0_%0d", i), 64'(in_rdy0), 64'd1);
         step();
         check($sformatf("pt_vld0_%0d", i), 64'(out_vld0), 64'h40);
         check($sformatf("pt_data6_%0d", i), lane0(6), 64'(i));
         check($sformatf("pt_occ0_%0d", i), 64'(occ0), 64'd1);
      end
      in_vld0 = 1'b0;
      step();
      check("pt_end_vld0", 64'(out_vld0), 64'h00);
      check("pt_end_occ0", 64'(occ0), 64'd0);

      // Fill all eight lanes with no drain
      out_rdy0 = '0; in_vld0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_sel0 = 3'(i); in_data0 = 64'h100 + 64'(i);
         step();
         check($sformatf("fill_occ0_%0d", i), 64'(occ0), 64'(i + 1));
      end
      in_vld0 = 1'b0;
      check("full_vld0", 64'(out_vld0), 64'hFF);
      check("full_data7", lane0(7), 64'h107);
      for (int s = 0; s < 8; s++) begin
         in_sel0 = 3'(s);
         #1 check($sformatf("full_rdy0_sel%0d", s), 64'(in_rdy0), 64'd0);
      end
      out_rdy0 = 8'h01;
      for (int s = 0; s < 8; s++) begin
         in_sel0 = 3'(s);
         #1 check($sformatf("full_drain0_rdy_sel%0d", s), 64'(in_rdy0), (s == 0) ? 64'd1 : 64'd0);
      end
      step();
      out_rdy0 = 8'hFF;
      step();
      out_rdy0 = '0;

      // Asynchronous reset with lanes 2 and 5 held on both channels
      in_vld0 = 1'b1; in_vld1 = 1'b1;
      in_sel0 = 3'd2; in_data0 = 64'h22; in_sel1 = 3'd2; in_data1 = 64'h1122;
      step();
      in_sel0 = 3'd5; in_data0 = 64'h55; in_sel1 = 3'd5; in_data1 = 64'h1155;
      step();
      in_vld0 = 1'b0; in_vld1 = 1'b0;
      check("pre_rst_vld0", 64'(out_vld0), 64'h24);
      check("pre_rst_vld1", 64'(out_vld1), 64'h24);
      check("pre_rst_occ1", 64'(occ1), 64'd2);
      #3 reset_n = 1'b0;
      #1;
      check("arst_vld0", 64'(out_vld0), 64'h00);
      check("arst_vld1", 64'(out_vld1), 64'h00);
      check("arst_occ0", 64'(occ0), 64'd0);
      check("arst_occ1", 64'(occ1), 64'd0);
      check("arst_rdy0", 64'(in_rdy0), 64'd0);
      check("arst_data0_5", lane0(5), 64'd0);
      check("arst_data1_2", lane1(2), 64'd0);
      step();
      #2 reset_n = 1'b1;
      step();
      for (int s = 0; s < 8; s++) begin
         in_sel0 = 3'(s);
         #1 check($sformatf("post_rst_rdy0_sel%0d", s), 64'(in_rdy0), 64'd1);
      end

      // Channel independence: ch1 lane 7 stalled, ch0 streams to lane 7
      in_vld1 = 1'b1; in_sel1 = 3'd7; in_data1 = 64'h7777; out_rdy1 = '0;
      step();
      in_vld1 = 1'b0;
      out_rdy0 = 8'h80; in_vld0 = 1'b1; in_sel0 = 3'd7;
      for (int i = 0; i < 4; i++) begin
         in_data0 = 64'h700 + 64'(i);
         #1 check($sformatf("ind_rdy0_%0d", i), 64'(in_rdy0), 64'd1);
         step();
         check($sformatf("ind_data0_%0d", i), lane0(7), 64'h700 + 64'(i));
         check($sformatf("ind_vld0_%0d", i), 64'(out_vld0), 64'h80);
      end
      check("ind_data1_7", lane1(7), 64'h7777);
      check("ind_vld1", 64'(out_vld1), 64'h80);
      check("ind_occ1", 64'(occ1), 64'd1);
      in_vld0 = 1'b0; out_rdy0 = 8'hFF;
      step();
      check("ind_occ0_drained", 64'(occ0), 64'd0);
      check("ind_occ1_held", 64'(occ1), 64'd1);
      for (int s = 0; s < 8; s++) begin
         in_sel1 = 3'(s);
         #1 check($sformatf("ind_rdy1_sel%0d", s), 64'(in_rdy1), (s == 7) ? 64'd0 : 64'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/demux1to8x2_reg.md
Name: demux1to8x2_reg

Overview:
- Dual, independent 1-to-8 demultiplexer with registered output lanes. It is the write/distribute counterpart of the 8:1 read-select muxes in the vadd datapath.
- Each channel takes one input word plus a 3-bit lane select and steers the word into one of eight per-lane holding registers. Each holding register drains through a valid/ready handshake.
- Used between the dispatch logic and the eight function-pipe input queues, with two channels per instance so two streams share one placement region.

Parameters:
- DW, 64, data width of each word.
- NL, 8, lane count (fixed; must equal 2**SW).
- SW, 3, lane-select width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset_n  input  1  asynchronous reset, active low; deassertion synchronized externally.
- in_vld0  input  1  channel 0 input word valid.
- in_sel0  input  SW  channel 0 destination lane.
- in_data0  input  DW  channel 0 input word.
- in_rdy0  output  1  channel 0 can accept this cycle.
- in_vld1, in_sel1, in_data1, in_rdy1: as above, for channel 1.
- out_vld0  output  NL  channel 0 per-lane valid (bit k = lane k).
- out_data0  output  NL*DW  channel 0 lane data; lane k at [k*DW +: DW].
- out_rdy0  input  NL  channel 0 per-lane ready from consumers.
- out_vld1, out_data1, out_rdy1: as above, for channel 1.
- occ0  output  4  channel 0 count of occupied lanes, 0..8.
- occ1  output  4  channel 1 count of occupied lanes, 0..8.

Behaviour:
- Channels are fully independent; no shared state or arbitration. Rules below apply per channel c.
- Reset (reset_n=0, asynchronous):
  - out_vld=0, out_data=0, occ=0.
  - in_rdy=0 while reset_n is low.
  - Held words are discarded. A transfer in progress at reset assertion is lost; no partial update.
- in_rdy:
  - in_rdy = reset_n & (~out_vld[in_sel] | out_rdy[in_sel]).
  - This is combinational from in_sel and out_rdy; it must not depend on in_vld.
- Accept occurs when in_vld & in_rdy at a rising edge. On accept:
  - lane in_sel loads in_data;
  - out_vld[in_sel] is set next cycle.
- Latency: 1 cycle from accept to out_vld. Throughput: 1 word/cycle/channel.
- Drain occurs on lane k when out_vld[k] & out_rdy[k] at an edge. If lane k is not reloaded that same edge, out_vld[k] clears.
- Drain and accept on the same lane at the same edge: the lane stays valid and holds the new word. This gives full throughput with no bubble.
- Stall: while out_vld[k]=1 and out_rdy[k]=0, out_data lane k holds stable and in_sel=k back-pressures (in_rdy=0). Inputs targeting other lanes are still accepted.
- in_vld=0: no lane loads, regardless of in_sel or in_data. X on in_sel/in_data is allowed when in_vld=0; in_rdy may then be X-free only after in_sel is known.
- Lane data registers load only on accept. They keep their value after drain; only out_vld qualifies them.
- occ = popcount(out_vld) of the registered vector, updated with out_vld. It reaches 8 when all lanes are held and none drain.
- Full condition: occ=8 with all out_rdy=0 forces in_rdy=0 for every sel.
- Empty condition: occ=0 forces in_rdy=1 for every sel.

Decomposition:
- Shared package: constants NL=8 and SW=3, and a lane-index function for the DW slice offset.
- One sub-module, demux1to8_reg: a single channel containing the in_rdy logic, eight holding registers with valid bits, and the occ popcount.
  - The top instantiates it twice.
  - keep_hierarchy applies on the sub-module so each channel places as a unit.

Test Plan:
- Reset: assert reset_n=0 with lanes 2 and 5 held -> out_vld0=0, out_vld1=0, occ=0, in_rdy=0 immediately (asynchronous). After release, in_rdy0=1 for any sel.
- Single transfer: in_vld0=1, sel0=3, data0=0xA5A5_0000_0000_0003, out_rdy0=0 -> next cycle out_vld0=8'h08, lane 3 data matches, occ0=1.
- Back-pressure: lane 3 held, out_rdy0[3]=0, sel0=3 -> in_rdy0=0 and lane 3 data unchanged. Switching sel0=4 -> in_rdy0=1 and lane 4 loads.
- Pass-through: sel0=6, data incrementing 1..10, out_rdy0[6]=1 every cycle -> in_rdy0=1 throughout, out_vld0[6] is high from cycle 2 to 11 with data 1..10 in order, occ0 ≤ 1.
- Fill to full: write lanes 0..7 with out_rdy0=0 -> occ0 increments to 8 and in_rdy0=0 for all sel. Raise out_rdy0[0] -> in_rdy0=1 only for sel0=0.
- Channel independence: channel 1 lane 7 stalled while channel 0 streams to lane 7 -> channel 0 is unaffected, in_rdy1=0 only for sel1=7, and occ0/occ1 differ as expected.
